// File: rtl/led_scanner_pkg.sv
// Shared constants and types for the LED pattern engine.
package led_scanner_pkg;

  localparam int unsigned MODE_W = 2;

  localparam logic [MODE_W-1:0] MODE_BOUNCE = 2'd0;
  localparam logic [MODE_W-1:0] MODE_UP     = 2'd1;
  localparam logic [MODE_W-1:0] MODE_DOWN   = 2'd2;
  localparam logic [MODE_W-1:0] MODE_FILL   = 2'd3;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/led_scanner_tick.sv
// Free-running prescaler with speed-selectable step tick; clears on request, holds while paused.
module led_scanner_tick #(
  parameter int unsigned DIV_W = 24,
  parameter int unsigned SPD_W = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clr,
  input  logic             hold,
  input  logic [SPD_W-1:0] speed,
  output logic             tick
);

  localparam logic [DIV_W-1:0] ALL_ONES = '1;

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;
  logic [DIV_W-1:0] mask;

  // Higher speed shortens the run of low bits that must all be ones.
  assign mask = ALL_ONES >> speed;
  assign tick = !hold && ((cnt_q & mask) == mask);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (!hold) begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_scanner.sv
// LED pattern engine: bounce / up / down / fill modes with speed select and pause.
// Optional PWM dimming when LED_SCANNER_DIM_EN is defined (adds dim_lvl input).
module led_scanner
  import led_scanner_pkg::*;
#(
  parameter int unsigned N_LED = 4,
  parameter int unsigned DIV_W = 24,
  parameter int unsigned SPD_W = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              mode_pls,
  input  logic              speed_pls,
  input  logic              pause_pls,
`ifdef LED_SCANNER_DIM_EN
  input  logic [3:0]        dim_lvl,
`endif
  output logic [N_LED-1:0]  led,
  output logic [MODE_W-1:0] mode,
  output logic [SPD_W-1:0]  speed,
  output logic              paused
);

  localparam int unsigned PW = $clog2(N_LED + 1);
  localparam logic [PW-1:0] POS_LAST = PW'(N_LED - 1);
  localparam logic [PW-1:0] POS_FULL = PW'(N_LED);
  localparam logic [N_LED-1:0] LED_ONES = '1;

  logic [MODE_W-1:0] mode_q, mode_d;
  logic [SPD_W-1:0]  speed_q, speed_d;
  logic              paused_q, paused_d;
  logic [PW-1:0]     pos_q, pos_d;
  dir_e              dir_q, dir_d;

  logic              tick;
  logic [PW-1:0]     pos_inc;
  logic [PW-1:0]     pos_dec;
  logic [N_LED-1:0]  pattern;

  led_scanner_tick #(
    .DIV_W (DIV_W),
    .SPD_W (SPD_W)
  ) u_tick (
    .CLK   (CLK),
    .RST   (RST),
    .clr   (mode_pls | speed_pls),
    .hold  (paused_q),
    .speed (speed_q),
    .tick  (tick)
  );

  assign pos_inc = pos_q + PW'(1);
  assign pos_dec = pos_q - PW'(1);

  always_ff @(posedge CLK) begin
    if (RST) begin
      mode_q   <= MODE_BOUNCE;
      speed_q  <= '0;
      paused_q <= 1'b0;
      pos_q    <= '0;
      dir_q    <= DIR_UP;
    end else begin
      mode_q   <= mode_d;
      speed_q  <= speed_d;
      paused_q <= paused_d;
      pos_q    <= pos_d;
      dir_q    <= dir_d;
    end
  end

  // Next state: a mode change restarts the pattern and wins over a coincident tick.
  always_comb begin
    mode_d   = mode_q;
    speed_d  = speed_q;
    paused_d = paused_q ^ pause_pls;
    pos_d    = pos_q;
    dir_d    = dir_q;

    if (speed_pls) begin
      speed_d = speed_q + SPD_W'(1);
    end

    if (mode_pls) begin
      mode_d = mode_q + MODE_W'(1);
      pos_d  = '0;
      dir_d  = DIR_UP;
    end else if (tick) begin
      case (mode_q)
        MODE_BOUNCE: begin
          if (dir_q == DIR_UP) begin
            pos_d = pos_inc;
            if (pos_inc == POS_LAST) dir_d = DIR_DOWN;
          end else begin
            pos_d = pos_dec;
            if (pos_dec == '0) dir_d = DIR_UP;
          end
        end
        MODE_UP, MODE_DOWN: pos_d = (pos_q == POS_LAST) ? '0 : pos_inc;
        MODE_FILL:          pos_d = (pos_q == POS_FULL) ? '0 : pos_inc;
        default:            pos_d = pos_q;
      endcase
    end
  end

  // Pattern decode from registered mode and position.
  always_comb begin
    pattern = '0;
    case (mode_q)
      MODE_DOWN: pattern = N_LED'(1) << (POS_LAST - pos_q);
      MODE_FILL: pattern = ~(LED_ONES << pos_q);
      default:   pattern = N_LED'(1) << pos_q;
    endcase
  end

`ifdef LED_SCANNER_DIM_EN
  logic [3:0] pwm_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      pwm_q <= '0;
    end else begin
      pwm_q <= pwm_q + 4'd1;
    end
  end

  assign led = pattern & {N_LED{pwm_q < dim_lvl}};
`else
  assign led = pattern;
`endif

  assign mode   = mode_q;
  assign speed  = speed_q;
  assign paused = paused_q;

endmodule

// File: tb/tb_led_scanner.sv
// Directed bench for led_scanner: queued expected LED values checked against the DUT outputs.
module tb_led_scanner;

  localparam int unsigned N_LED = 4;
  localparam int unsigned DIV_W = 4;
  localparam int unsigned SPD_W = 2;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             RST5 = 1'b1;
  logic             mode_pls = 1'b0;
  logic             speed_pls = 1'b0;
  logic             pause_pls = 1'b0;

  logic [N_LED-1:0] led;
  logic [1:0]       mode;
  logic [SPD_W-1:0] speed;
  logic             paused;

  logic [4:0]       led5;
  logic [1:0]       mode5;
  logic [SPD_W-1:0] speed5;
  logic             paused5;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] exp_q[$];
  string       tag_q[$];

  led_scanner #(.N_LED(N_LED), .DIV_W(DIV_W), .SPD_W(SPD_W)) u_dut (
    .CLK       (CLK),
    .RST       (RST),
    .mode_pls  (mode_pls),
    .speed_pls (speed_pls),
    .pause_pls (pause_pls),
    .led       (led),
    .mode      (mode),
    .speed     (speed),
    .paused    (paused)
  );

  led_scanner #(.N_LED(5), .DIV_W(DIV_W), .SPD_W(SPD_W)) u_dut5 (
    .CLK       (CLK),
    .RST       (RST5),
    .mode_pls  (1'b0),
    .speed_pls (1'b0),
    .pause_pls (1'b0),
    .led       (led5),
    .mode      (mode5),
    .speed     (speed5),
    .paused    (paused5)
  );

  always #5 CLK = ~CLK;

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input logic [15:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic pop_chk(input bit use5);
    logic [15:0] e;
    string       t;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL sb_empty: observed empty queue expected an entry");
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      chk(t, use5 ? 16'(led5) : 16'(led), e);
    end
  endtask

  task automatic expect_now(input string tag, input logic [15:0] v);
    push(tag, v);
    pop_chk(1'b0);
  endtask

  // Wait one step period before each queued expectation.
  task automatic drain(input int period, input bit use5);
    while (exp_q.size() > 0) begin
      wait_cyc(period);
      pop_chk(use5);
    end
  endtask

  task automatic pulse(input bit m, input bit s, input bit p);
    mode_pls  = m;
    speed_pls = s;
    pause_pls = p;
    wait_cyc(1);
    mode_pls  = 1'b0;
    speed_pls = 1'b0;
    pause_pls = 1'b0;
  endtask

  initial begin
    // Reset and free-running bounce
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    expect_now("rst_led", 16'h1);
    chk("rst_mode", 16'(mode), 16'd0);
    chk("rst_speed", 16'(speed), 16'd0);
    chk("rst_paused", 16'(paused), 16'd0);
    wait_cyc(15);
    expect_now("bounce_hold15", 16'h1);
    wait_cyc(1);
    expect_now("bounce_step1", 16'h2);
    push("bounce", 16'h4); push("bounce", 16'h8); push("bounce", 16'h4);
    push("bounce", 16'h2); push("bounce", 16'h1); push("bounce", 16'h2);
    drain(16, 1'b0);

    // UP mode entered mid-period
    wait_cyc(5);
    pulse(1'b1, 1'b0, 1'b0);
    expect_now("up_start", 16'h1);
    chk("up_mode", 16'(mode), 16'd1);
    wait_cyc(15);
    expect_now("up_hold15", 16'h1);
    wait_cyc(1);
    expect_now("up_step1", 16'h2);
    push("up", 16'h4); push("up", 16'h8); push("up", 16'h1);
    drain(16, 1'b0);

    // DOWN then FILL
    pulse(1'b1, 1'b0, 1'b0);
    expect_now("down_start", 16'h8);
    chk("down_mode", 16'(mode), 16'd2);
    push("down", 16'h4); push("down", 16'h2); push("down", 16'h1); push("down", 16'h8);
    drain(16, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    expect_now("fill_start", 16'h0);
    chk("fill_mode", 16'(mode), 16'd3);
    push("fill", 16'h1); push("fill", 16'h3); push("fill", 16'h7);
    push("fill", 16'hf); push("fill", 16'h0);
    drain(16, 1'b0);

    // Speed select: 3 gives a 2-cycle period, wrap back to 0 gives 16
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    chk("speed3", 16'(speed), 16'd3);
    expect_now("spd3_led0", 16'h0);
    wait_cyc(1);
    expect_now("spd3_hold1", 16'h0);
    wait_cyc(1);
    expect_now("spd3_step1", 16'h1);
    wait_cyc(2);
    expect_now("spd3_step2", 16'h3);
    pulse(1'b0, 1'b1, 1'b0);
    chk("speed_wrap", 16'(speed), 16'd0);
    expect_now("spd0_keep_pos", 16'h3);
    wait_cyc(15);
    expect_now("spd0_hold15", 16'h3);
    wait_cyc(1);
    expect_now("spd0_step", 16'h7);

    // mode_pls in the same cycle as a tick restarts rather than advances
    wait_cyc(15);
    expect_now("pre_coinc", 16'h7);
    pulse(1'b1, 1'b0, 1'b0);
    expect_now("coinc_mode_led", 16'h1);
    chk("coinc_mode", 16'(mode), 16'd0);
    wait_cyc(15);
    expect_now("coinc_hold15", 16'h1);
    wait_cyc(1);
    expect_now("coinc_step1", 16'h2);
    wait_cyc(16);
    expect_now("coinc_step2", 16'h4);

    // Pause freezes; mode change still honoured while paused
    wait_cyc(3);
    pulse(1'b0, 1'b0, 1'b1);
    chk("paused_set", 16'(paused), 16'd1);
    expect_now("pause_led", 16'h4);
    wait_cyc(100);
    expect_now("pause_hold100", 16'h4);
    pulse(1'b1, 1'b0, 1'b0);
    chk("pause_mode", 16'(mode), 16'd1);
    chk("pause_still", 16'(paused), 16'd1);
    expect_now("pause_mode_led", 16'h1);
    wait_cyc(50);
    expect_now("pause_mode_hold", 16'h1);
    pulse(1'b0, 1'b0, 1'b1);
    chk("resumed", 16'(paused), 16'd0);
    wait_cyc(15);
    expect_now("resume_hold15", 16'h1);
    wait_cyc(1);
    expect_now("resume_step", 16'h2);

    // Tick coincident with the pausing pulse still advances once
    wait_cyc(15);
    pulse(1'b0, 1'b0, 1'b1);
    expect_now("tick_pause_adv", 16'h4);
    chk("tick_pause_flag", 16'(paused), 16'd1);
    wait_cyc(20);
    expect_now("tick_pause_hold", 16'h4);
    pulse(1'b0, 1'b0, 1'b1);
    wait_cyc(15);
    expect_now("tick_resume_hold", 16'h4);
    wait_cyc(1);
    expect_now("tick_resume_step", 16'h8);

    // All three pulses together
    pulse(1'b1, 1'b1, 1'b1);
    chk("all3_mode", 16'(mode), 16'd2);
    chk("all3_speed", 16'(speed), 16'd1);
    chk("all3_paused", 16'(paused), 16'd1);
    expect_now("all3_led", 16'h8);
    pulse(1'b0, 1'b0, 1'b1);
    wait_cyc(7);
    expect_now("spd1_hold7", 16'h8);
    wait_cyc(1);
    expect_now("spd1_step", 16'h4);

    // RST while paused in FILL at 0111
    pulse(1'b1, 1'b0, 1'b0);
    expect_now("fill2_start", 16'h0);
    push("fill2", 16'h1); push("fill2", 16'h3); push("fill2", 16'h7);
    drain(8, 1'b0);
    pulse(1'b0, 1'b0, 1'b1);
    RST = 1'b1;
    wait_cyc(1);
    RST = 1'b0;
    expect_now("rst2_led", 16'h1);
    chk("rst2_mode", 16'(mode), 16'd0);
    chk("rst2_speed", 16'(speed), 16'd0);
    chk("rst2_paused", 16'(paused), 16'd0);
    wait_cyc(15);
    expect_now("rst2_hold15", 16'h1);
    wait_cyc(1);
    expect_now("rst2_step", 16'h2);

    // Five-LED bounce: period of 8 ticks, endpoints not repeated
    RST5 = 1'b0;
    chk("n5_rst_led", 16'(led5), 16'h1);
    push("n5", 16'h02); push("n5", 16'h04); push("n5", 16'h08);
    push("n5", 16'h10); push("n5", 16'h08); push("n5", 16'h04);
    push("n5", 16'h02); push("n5", 16'h01); push("n5", 16'h02);
    drain(16, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/led_scanner.md
Name: led_scanner

Overview:
- Parametrised LED pattern engine: drives N_LED LEDs with a moving pattern, stepped by a programmable clock-divider tick.
- Four modes: bounce, index-up, index-down, bar-fill.
- Run-time speed select and pause/resume.
- Inputs are single-cycle pulses from the team's existing button debouncer; sits between debouncers and board LED pins.

Parameters:
- N_LED, 4, number of LEDs; legal range 2..16.
- DIV_W, 24, prescaler width; slowest tick period is 2^DIV_W cycles; minimum 4.
- SPD_W, 2, speed-select width; speed s in 0..2^SPD_W-1; require 2^SPD_W-1 < DIV_W.

Ports:
- CLK  in  1  clock
- RST  in  1  reset, synchronous, active-high
- mode_pls  in  1  one-cycle pulse: advance mode
- speed_pls  in  1  one-cycle pulse: advance speed
- pause_pls  in  1  one-cycle pulse: toggle pause
- led  out  N_LED  LED drive, bit 0 = rightmost
- mode  out  2  current mode
- speed  out  SPD_W  current speed
- paused  out  1  high while frozen

Behaviour:
- Reset, the cycle after RST is high: mode=0 (BOUNCE), speed=0, paused=0, pos=0, dir=up, prescaler=0, led=...0001.
- Modes: 0 BOUNCE, 1 UP, 2 DOWN, 3 FILL. mode_pls advances 0->1->2->3->0.
- Prescaler: DIV_W-bit counter, +1 per cycle while paused=0, wraps freely, holds while paused.
- tick = !paused && low (DIV_W-speed) prescaler bits all ones.
- Tick period is 2^(DIV_W-speed) cycles.
- pos register: width clog2(N_LED+1).
- BOUNCE: pos 0,1,..,N-1,N-2,..,1,0,...
  - Endpoints are not repeated; period 2N-2 ticks.
  - dir flips in the same cycle pos reaches 0 or N-1.
  - led = one-hot at pos.
- UP: pos 0..N-1 then wraps to 0; led = one-hot at pos.
- DOWN: same pos sequence as UP; led = one-hot at N-1-pos.
- FILL: pos 0..N then wraps to 0; led = (1<<pos)-1.
  - Sequence runs all-off up to all-on; period N+1 ticks.
- led is combinational from registered (mode, pos). It changes in the cycle after the tick cycle; no additional latency.
- mode_pls:
  - mode advances.
  - pos=0, dir=up, prescaler=0.
  - paused unchanged.
  - New mode's start pattern appears next cycle.
- speed_pls: speed+1, wrapping to 0 after max; prescaler=0; pos unchanged.
- pause_pls: toggles paused.
  - While paused, prescaler, pos and dir freeze and led holds.
  - mode_pls and speed_pls are still honoured while paused.
- Simultaneous events:
  - RST overrides everything.
  - mode_pls overrides a coincident tick (pos goes to 0, not advanced).
  - mode_pls, speed_pls and pause_pls in the same cycle all take effect.
  - A tick in the same cycle as a pause_pls that sets paused still advances pos once.
- RST mid-pattern returns to reset state in one cycle, regardless of paused.

Optional Feature:
- Macro: LED_SCANNER_DIM_EN.
- Defined:
  - Adds a 4-bit free-running PWM counter and input dim_lvl[3:0].
  - led = pattern AND (pwm_cnt < dim_lvl). dim_lvl=0 means dark; dim_lvl=15 means 15/16 duty.
  - PWM counter resets to 0 and never pauses.
- Undefined: no port and no counter; led = pattern.

Decomposition:
- Package led_scanner_pkg holds:
  - mode constants MODE_BOUNCE=2'd0, MODE_UP=2'd1, MODE_DOWN=2'd2, MODE_FILL=2'd3.
  - 2-bit mode width constant.
- Sub-module led_scanner_tick: prescaler plus tick generation.
  - Inputs: CLK, RST, clr, hold, speed.
  - Output: tick.
- Pattern FSM/decoder stays in the top.

Test Plan (N_LED=4, DIV_W=4, SPD_W=2):
- Reset then free run -> led 0001 immediately; changes every 16 cycles: 0010,0100,1000,0100,0010,0001,0010.
- One mode_pls mid-tick -> led 0001 next cycle, then 0010 exactly 16 cycles later; repeat in UP gives 0001,0010,0100,1000,0001.
- Two more mode_pls (DOWN) -> 1000,0100,0010,0001,1000; one more (FILL) -> 0000,0001,0011,0111,1111,0000.
- Three speed_pls -> speed=3, tick period 2 cycles; fourth -> speed=0, period 16.
- pause_pls at led=0100 -> led held 100 cycles and paused=1; mode_pls while paused -> mode advances, led shows start pattern and stays frozen; pause_pls resumes with first step 16 cycles later.
- mode_pls coincident with tick, and RST during FILL at 0111 -> pos=0 (no advance); RST gives led=0001, mode=0, speed=0, paused=0. Repeat bounce with N_LED=5 -> period 8 ticks.
